tambor_contador_param: RTL and testbench

Parametrised successor of the toy-drum counter. Each accepted piezo hit steps a BCD up/down counter. The counter wraps at a programmable maximum and drives a time-multiplexed N-digit seven-segment display, three 8-bit RGB LED banks and a direction-dependent buzzer beep. The block sits directly between the board pins (piezo, push button) and the display, LED and buzzer pins. It replaces the fixed 0–9, two-digit, reset-less version with clean asynchronous reset, consecutive-stability debouncing and a counter wider than one decimal digit.

---
 rtl/tambor_contador_param.sv | 241 ++++++++++++++++++++++++
 tb/tb_tambor_contador_param.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/tambor_contador_param.sv
// Drum-hit BCD up/down counter with a multiplexed seven-segment display, RGB LED banks and a beep generator.
// Beep FSM states: IDLE = buzzer silent | BEEP = tone running for BEEP_CYCLES after the last hit.
module tambor_contador_param #(
    parameter int DEB_CYCLES   = 2_500_000,
    parameter int DIGITS       = 2,
    parameter int MAX_COUNT    = 99,
    parameter int SCAN_CYCLES  = 208_334,
    parameter int TONE_UP_HALF = 56_818,
    parameter int TONE_DN_HALF = 95_555,
    parameter int BEEP_CYCLES  = 2_500_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  piezo,
    input  logic                  up_down,
    output logic [7:0]            siete_seg,
    output logic [DIGITS-1:0]     dig_sel,
    output logic [7:0]            leds_r,
    output logic [7:0]            leds_g,
    output logic [7:0]            leds_b,
    output logic                  buzzer,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  dir
);

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 8'b00000011;
            4'd1:    glyph = 8'b10011111;
            4'd2:    glyph = 8'b00100101;
            4'd3:    glyph = 8'b00001101;
            4'd4:    glyph = 8'b10011001;
            4'd5:    glyph = 8'b01001001;
            4'd6:    glyph = 8'b01000001;
            4'd7:    glyph = 8'b00011111;
            4'd8:    glyph = 8'b00000001;
            4'd9:    glyph = 8'b00001001;
            default: glyph = 8'hFF;
        endcase
    endfunction

    localparam int TONE_MAX = (TONE_UP_HALF > TONE_DN_HALF) ? TONE_UP_HALF : TONE_DN_HALF;
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int SW = $clog2(SCAN_CYCLES + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int TW = $clog2(TONE_MAX + 1);
    localparam int BW = $clog2(BEEP_CYCLES + 1);

    localparam logic [4*DIGITS-1:0] MAX_BCD   = to_bcd(MAX_COUNT);
    localparam logic [DW-1:0]       DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [SW-1:0]       SCAN_LAST = SW'(SCAN_CYCLES - 1);
    localparam logic [IW-1:0]       IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [TW-1:0]       UP_LAST   = TW'(TONE_UP_HALF - 1);
    localparam logic [TW-1:0]       DN_LAST   = TW'(TONE_DN_HALF - 1);
    localparam logic [BW-1:0]       BEEP_LAST = BW'(BEEP_CYCLES - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, BEEP = 1'b1} state_t;

    // Channel 0 is the piezo, channel 1 the direction button.
    logic [1:0]         sync1, sync2, deb, rise;
    logic [1:0][DW-1:0] deb_cnt;

    // deb_cnt measures how long the synchronised level has disagreed with the accepted one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            deb     <= '0;
            rise    <= '0;
            deb_cnt <= '0;
        end else begin
            sync1 <= {up_down, piezo};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                rise[i] <= 1'b0;
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                    rise[i]    <= sync2[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic [4*DIGITS-1:0] cnt_inc, cnt_dec;

    always_comb begin
        logic carry, borrow;
        cnt_inc = count_bcd;
        cnt_dec = count_bcd;
        carry   = 1'b1;
        borrow  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (count_bcd[4*i +: 4] == 4'd9) begin
                    cnt_inc[4*i +: 4] = 4'd0;
                end else begin
                    cnt_inc[4*i +: 4] = count_bcd[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (count_bcd[4*i +: 4] == 4'd0) begin
                    cnt_dec[4*i +: 4] = 4'd9;
                end else begin
                    cnt_dec[4*i +: 4] = count_bcd[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_bcd <= '0;
            dir       <= 1'b0;
        end else begin
            if (rise[0]) begin
                if (!dir) count_bcd <= (count_bcd == MAX_BCD) ? '0 : cnt_inc;
                else      count_bcd <= (count_bcd == '0) ? MAX_BCD : cnt_dec;
            end
            if (rise[1]) dir <= ~dir;
        end
    end

    assign leds_r = {8{count_bcd[2]}};
    assign leds_g = {8{count_bcd[1]}};
    assign leds_b = {8{count_bcd[0]}};

    logic [SW-1:0] scan_cnt;
    logic [IW-1:0] scan_idx;
    logic [7:0]    seg_nxt;

    always_comb begin
        logic       upper_zero, sel_blank;
        logic [3:0] sel_nib;
        upper_zero = 1'b1;
        sel_blank  = 1'b0;
        sel_nib    = 4'd0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero & (count_bcd[4*i +: 4] == 4'd0);
            if (IW'(i) == scan_idx) begin
                sel_nib   = count_bcd[4*i +: 4];
                sel_blank = upper_zero && (i != 0);
            end
        end
        seg_nxt = sel_blank ? 8'hFF : glyph(sel_nib);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt  <= '0;
            scan_idx  <= '0;
            dig_sel   <= '1;
            siete_seg <= 8'hFF;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            dig_sel   <= ~(DIGITS'(1) << scan_idx);
            siete_seg <= seg_nxt;
        end
    end

    state_t        state, next_state;
    logic [BW-1:0] beep_cnt, beep_cnt_n;
    logic [TW-1:0] tone_cnt, tone_cnt_n;
    logic          tone_dn, tone_dn_n, buzzer_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beep_cnt <= '0;
            tone_cnt <= '0;
            tone_dn  <= 1'b0;
            buzzer   <= 1'b0;
        end else begin
            state    <= next_state;
            beep_cnt <= beep_cnt_n;
            tone_cnt <= tone_cnt_n;
            tone_dn  <= tone_dn_n;
            buzzer   <= buzzer_n;
        end
    end

    always_comb begin
        next_state = state;
        if (rise[0])
            next_state = BEEP;
        else if (state == BEEP && beep_cnt == BEEP_LAST)
            next_state = IDLE;
    end

    // A hit restarts the beep from scratch, latching the pre-toggle direction as the tone.
    always_comb begin
        beep_cnt_n = beep_cnt;
        tone_cnt_n = tone_cnt;
        tone_dn_n  = tone_dn;
        buzzer_n   = buzzer;
        if (rise[0]) begin
            beep_cnt_n = '0;
            tone_cnt_n = '0;
            tone_dn_n  = dir;
            buzzer_n   = 1'b0;
        end else if (state == BEEP) begin
            if (beep_cnt == BEEP_LAST) begin
                beep_cnt_n = '0;
                tone_cnt_n = '0;
                buzzer_n   = 1'b0;
            end else begin
                beep_cnt_n = beep_cnt + 1'b1;
                if (tone_cnt == (tone_dn ? DN_LAST : UP_LAST)) begin
                    tone_cnt_n = '0;
                    buzzer_n   = ~buzzer;
                end else begin
                    tone_cnt_n = tone_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tambor_contador_param.sv
// Bench for tambor_contador_param: event-scheduled behavioural model checked every cycle plus literal spot checks.
module tb_tambor_contador_param;
    localparam int DEB = 4, DIG = 2, MAXC = 12, SCAN = 3, TUP = 2, TDN = 5, BEEPC = 20;
    // Raw edge driven at a falling edge becomes visible on the 7th rising edge: 2 sync + DEB + 1.
    localparam int LAT = 7;

    logic       clk = 1'b0, rst_n = 1'b0, piezo = 1'b0, up_down = 1'b0;
    logic [7:0] siete_seg, leds_r, leds_g, leds_b, count_bcd;
    logic [1:0] dig_sel;
    logic       buzzer, dir;

    tambor_contador_param #(
        .DEB_CYCLES(DEB), .DIGITS(DIG), .MAX_COUNT(MAXC), .SCAN_CYCLES(SCAN),
        .TONE_UP_HALF(TUP), .TONE_DN_HALF(TDN), .BEEP_CYCLES(BEEPC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .piezo(piezo), .up_down(up_down),
        .siete_seg(siete_seg), .dig_sel(dig_sel),
        .leds_r(leds_r), .leds_g(leds_g), .leds_b(leds_b),
        .buzzer(buzzer), .count_bcd(count_bcd), .dir(dir)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int edge_n = 0, rel_edge = 0;
    int pq[$], uq[$];
    int m_count = 0, b_edge = 0, b_half = TUP;
    bit m_dir = 1'b0, b_active = 1'b0;
    logic [7:0] glyph_t [10] = '{8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101,
                                 8'b10011001, 8'b01001001, 8'b01000001, 8'b00011111,
                                 8'b00000001, 8'b00001001};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] bcd8(input int v);
        return 8'(((v / 10) % 10) * 16 + (v % 10));
    endfunction

    // Model: count, direction and beep advance on the scheduled edges; every output checked each cycle.
    initial begin
        int prev, j, idx, dv, d;
        bit p, u, blank, exp_buz;
        logic [7:0] es;
        forever begin
            @(posedge clk);
            edge_n++;
            prev = m_count;
            if (!rst_n) begin
                m_count = 0; m_dir = 1'b0; b_active = 1'b0;
                pq.delete(); uq.delete();
            end else begin
                p = 1'b0; u = 1'b0;
                while (pq.size() > 0 && pq[0] == edge_n) begin p = 1'b1; void'(pq.pop_front()); end
                while (uq.size() > 0 && uq[0] == edge_n) begin u = 1'b1; void'(uq.pop_front()); end
                if (p) begin
                    if (!m_dir) m_count = (m_count == MAXC) ? 0 : m_count + 1;
                    else        m_count = (m_count == 0) ? MAXC : m_count - 1;
                    b_active = 1'b1; b_edge = edge_n; b_half = m_dir ? TDN : TUP;
                end
                if (u) m_dir = !m_dir;
            end
            #1;
            if (!rst_n) begin
                chk("rst_count", count_bcd, 0);
                chk("rst_dir", dir, 0);
                chk("rst_seg", siete_seg, 8'hFF);
                chk("rst_dig", dig_sel, 2'b11);
                chk("rst_leds", {leds_r, leds_g, leds_b}, 0);
                chk("rst_buzzer", buzzer, 0);
            end else begin
                chk("count", count_bcd, bcd8(m_count));
                chk("dir", dir, m_dir);
                chk("leds_r", leds_r, ((m_count % 10) & 4) ? 8'hFF : 8'h00);
                chk("leds_g", leds_g, ((m_count % 10) & 2) ? 8'hFF : 8'h00);
                chk("leds_b", leds_b, ((m_count % 10) & 1) ? 8'hFF : 8'h00);
                d = edge_n - b_edge;
                exp_buz = b_active && (d < BEEPC) && (((d / b_half) % 2) == 1);
                chk("buzzer", buzzer, exp_buz);
                j = edge_n - rel_edge;
                idx = ((j - 1) / SCAN) % DIG;
                dv = (idx == 0) ? prev % 10 : (prev / 10) % 10;
                blank = (idx == 1) && (prev / 10 == 0);
                es = blank ? 8'hFF : glyph_t[dv];
                chk("dig_sel", dig_sel, (idx == 0) ? 2'b10 : 2'b01);
                chk("seg", siete_seg, es);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hit();
        piezo = 1'b1; pq.push_back(edge_n + LAT);
        cyc(8); piezo = 1'b0; cyc(8);
    endtask

    task automatic press();
        up_down = 1'b1; uq.push_back(edge_n + LAT);
        cyc(8); up_down = 1'b0; cyc(8);
    endtask

    task automatic both();
        piezo = 1'b1; up_down = 1'b1;
        pq.push_back(edge_n + LAT); uq.push_back(edge_n + LAT);
        cyc(8); piezo = 1'b0; up_down = 1'b0; cyc(8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected run to complete");
        $fatal(1);
    end

    initial begin
        int seen_u, seen_t;
        cyc(3);
        chk("lit_rst_count", count_bcd, 8'h00);
        chk("lit_rst_seg", siete_seg, 8'hFF);
        chk("lit_rst_dig", dig_sel, 2'b11);
        rst_n = 1'b1; rel_edge = edge_n;
        cyc(1);
        chk("lit_first_glyph", siete_seg, 8'b00000011);
        cyc(3);

        piezo = 1'b1; cyc(DEB - 1); piezo = 1'b0; cyc(12);
        chk("lit_glitch_count", count_bcd, 8'h00);
        chk("lit_glitch_buzzer", buzzer, 1'b0);

        for (int i = 1; i <= 13; i++) begin
            hit();
            if (i == 5) begin
                chk("lit_count5", count_bcd, 8'h05);
                chk("lit_leds5", {leds_r, leds_g, leds_b}, 24'hFF00FF);
            end
            if (i == 9)  chk("lit_count9", count_bcd, 8'h09);
            if (i == 10) chk("lit_count10", count_bcd, 8'h10);
            if (i == 12) chk("lit_count12", count_bcd, 8'h12);
            if (i == 13) chk("lit_wrap_up", count_bcd, 8'h00);
        end

        press();
        chk("lit_dir_down", dir, 1'b1);
        hit();
        chk("lit_wrap_down", count_bcd, 8'h12);
        cyc(12);

        press();
        repeat (8) hit();
        chk("lit_count7", count_bcd, 8'h07);
        cyc(12);
        seen_u = 0; seen_t = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (dig_sel == 2'b10) begin
                chk("lit_scan_units", siete_seg, 8'b00011111); seen_u++;
            end else begin
                chk("lit_scan_tens", {dig_sel, siete_seg}, {2'b01, 8'hFF}); seen_t++;
            end
        end
        chk("lit_scan_both", (seen_u > 0) && (seen_t > 0), 1'b1);

        press(); hit(); hit();
        chk("lit_count5b", count_bcd, 8'h05);
        press();
        chk("lit_dir_up", dir, 1'b0);
        both();
        chk("lit_simul_count", count_bcd, 8'h06);
        chk("lit_simul_dir", dir, 1'b1);

        hit(); hit();
        piezo = 1'b1; pq.push_back(edge_n + LAT);
        cyc(8); piezo = 1'b0; cyc(5);
        chk("lit_pre_rst_count", count_bcd, 8'h03);
        chk("lit_pre_rst_buzzer", buzzer, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("lit_async_buzzer", buzzer, 1'b0);
        chk("lit_async_count", count_bcd, 8'h00);
        chk("lit_async_dig", dig_sel, 2'b11);
        cyc(3);
        rst_n = 1'b1; rel_edge = edge_n;
        cyc(40);
        chk("lit_post_rst_count", count_bcd, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
